// File: rtl/regfile_pc_multiport.sv
// Register file (2 write / 2 async read ports) with program counter; reads are combinational,
// writes and PC update land on the rising clk edge, and there is no backpressure.
module regfile_pc_multiport #(
    parameter int          DATA_W   = 8,
    parameter int          NUM_REGS = 4,
    parameter int          ADDR_W   = 2,
    parameter int          PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RST = '0,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   pc_load_val,
    input  logic              stall,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   pc_next,
    output logic              wr_conflict
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic              conflict_q;
    logic              conflict_d;
    logic              w0_ok;
    logic              w1_ok;
    logic              w0_in_range;
    logic              w1_in_range;

    always_comb begin
        w0_in_range = 1'b0;
        w1_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr0 == ADDR_W'(i)) w0_in_range = 1'b1;
            if (waddr1 == ADDR_W'(i)) w1_in_range = 1'b1;
        end
    end

    // A write is effective only if in range, not to a hardwired R0, and not under reset.
    assign w0_ok = we0 && w0_in_range && !(ZERO_R0 && waddr0 == '0) && !reset;
    assign w1_ok = we1 && w1_in_range && !(ZERO_R0 && waddr1 == '0) && !reset;
    assign conflict_d = w0_ok && w1_ok && (waddr0 == waddr1);

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        rdata0 = '0;
        rdata1 = '0;
        for (int p = 0; p < 2; p++) begin
            ra = (p == 0) ? raddr0 : raddr1;
            rd = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ra == ADDR_W'(i)) rd = regs_q[i];
            end
            if (BYPASS) begin
                if (w0_ok && waddr0 == ra) rd = wdata0;
                if (w1_ok && waddr1 == ra) rd = wdata1;
            end
            if (ZERO_R0 && ra == '0) rd = '0;
            if (p == 0) rdata0 = rd;
            else        rdata1 = rd;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (reset)        pc_d = PC_RST;
        else if (stall)   pc_d = pc_q;
        else if (pc_load) pc_d = pc_load_val;
        else if (pc_inc)  pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc_q       <= PC_RST;
            conflict_q <= 1'b0;
        end else begin
            // Port 1 is applied last so it wins on an address collision.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w0_ok && waddr0 == ADDR_W'(i)) regs_q[i] <= wdata0;
                if (w1_ok && waddr1 == ADDR_W'(i)) regs_q[i] <= wdata1;
            end
            pc_q       <= pc_d;
            conflict_q <= conflict_d;
        end
    end

    assign pc_out      = pc_q;
    assign pc_next     = pc_d;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_pc_multiport.sv
// Directed bench for regfile_pc_multiport: three configurations share one stimulus stream;
// expectations are queued by the stimulus and popped/compared by a monitor process.
module tb_regfile_pc_multiport;

    logic       clk = 1'b0;
    logic       reset;
    logic       we0, we1, pc_inc, pc_load, stall;
    logic [1:0] waddr0, waddr1, raddr0, raddr1;
    logic [7:0] wdata0, wdata1, pc_load_val;

    logic [7:0] a_rd0, a_rd1, a_pc, a_pcn;
    logic       a_conf;
    logic [7:0] b_rd0, b_rd1, b_pc, b_pcn;
    logic       b_conf;
    logic [7:0] c_rd0, c_rd1, c_pc, c_pcn;
    logic       c_conf;

    always #5 clk = ~clk;

    regfile_pc_multiport u_a (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .rdata0(a_rd0), .raddr1(raddr1), .rdata1(a_rd1),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .stall(stall),
        .pc_out(a_pc), .pc_next(a_pcn), .wr_conflict(a_conf)
    );

    regfile_pc_multiport #(.BYPASS(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .rdata0(b_rd0), .raddr1(raddr1), .rdata1(b_rd1),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .stall(stall),
        .pc_out(b_pc), .pc_next(b_pcn), .wr_conflict(b_conf)
    );

    regfile_pc_multiport #(.NUM_REGS(3), .ZERO_R0(1'b1)) u_c (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .rdata0(c_rd0), .raddr1(raddr1), .rdata1(c_rd1),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .stall(stall),
        .pc_out(c_pc), .pc_next(c_pcn), .wr_conflict(c_conf)
    );

    typedef enum int {
        A_RD0, A_RD1, A_PC, A_PCN, A_CONF, B_RD0, C_RD0, C_RD1, C_CONF
    } sel_t;

    typedef struct {
        sel_t       sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t queue_q[$];
    event smp_ev;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] observe(sel_t s);
        case (s)
            A_RD0:  return a_rd0;
            A_RD1:  return a_rd1;
            A_PC:   return a_pc;
            A_PCN:  return a_pcn;
            A_CONF: return {7'd0, a_conf};
            B_RD0:  return b_rd0;
            C_RD0:  return c_rd0;
            C_RD1:  return c_rd1;
            default: return {7'd0, c_conf};
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        logic [7:0] act;
        forever begin
            @(smp_ev);
            while (queue_q.size() > 0) begin
                e   = queue_q.pop_front();
                act = observe(e.sel);
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", e.name, act, e.val, $time);
                end
            end
        end
    end

    task automatic expect_val(input sel_t s, input logic [7:0] v, input string n);
        exp_t e;
        e.sel = s; e.val = v; e.name = n;
        queue_q.push_back(e);
    endtask

    task automatic flush();
        -> smp_ev;
        #1;
        if (queue_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_drain: got %0d pending expected 0", queue_q.size());
            queue_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        pc_inc = 0; pc_load = 0; pc_load_val = 0; stall = 0;
    endtask

    initial begin
        reset = 1'b1; raddr0 = 0; raddr1 = 0;
        clear_in();
        #3;
        expect_val(A_RD0, 8'h00, "rst_rd0");
        expect_val(A_RD1, 8'h00, "rst_rd1");
        expect_val(A_PC, 8'h00, "rst_pc");
        expect_val(A_PCN, 8'h00, "rst_pcn");
        expect_val(A_CONF, 8'h00, "rst_conf");
        flush();

        // Load R1=0x5A and PC=0x10, then reset mid-cycle with a write and increment pending.
        @(negedge clk);
        reset = 1'b0;
        we0 = 1; waddr0 = 1; wdata0 = 8'h5A; pc_load = 1; pc_load_val = 8'h10;
        tick();
        clear_in();
        raddr0 = 1;
        expect_val(A_RD0, 8'h5A, "pre_rst_r1");
        expect_val(A_PC, 8'h10, "pre_rst_pc");
        flush();
        we0 = 1; waddr0 = 1; wdata0 = 8'h33; pc_inc = 1;
        #2;
        reset = 1'b1;
        #1;
        expect_val(A_RD0, 8'h00, "midrst_rd0");
        expect_val(B_RD0, 8'h00, "midrst_b_rd0");
        expect_val(A_PC, 8'h00, "midrst_pc");
        expect_val(A_PCN, 8'h00, "midrst_pcn");
        flush();
        @(negedge clk);
        reset = 1'b0;
        tick();
        clear_in();
        expect_val(A_RD0, 8'h33, "post_rst_write");
        expect_val(A_PC, 8'h01, "post_rst_inc");
        flush();

        // Bypass vs. registered read of a same-cycle write.
        raddr0 = 2; we0 = 1; waddr0 = 2; wdata0 = 8'h3C;
        #1;
        expect_val(A_RD0, 8'h3C, "byp_before");
        expect_val(B_RD0, 8'h00, "nobyp_before");
        flush();
        tick();
        clear_in();
        expect_val(A_RD0, 8'h3C, "byp_after");
        expect_val(B_RD0, 8'h3C, "nobyp_after");
        flush();

        // Dual write to distinct addresses.
        we0 = 1; waddr0 = 2; wdata0 = 8'h11; we1 = 1; waddr1 = 3; wdata1 = 8'h22;
        raddr0 = 2; raddr1 = 3;
        tick();
        clear_in();
        expect_val(A_RD0, 8'h11, "dual_r2");
        expect_val(A_RD1, 8'h22, "dual_r3");
        expect_val(A_CONF, 8'h00, "dual_conf");
        expect_val(C_RD0, 8'h11, "c_dual_r2");
        expect_val(C_RD1, 8'h00, "c_oor_r3");
        flush();

        // Same-address conflict: port 1 wins, flag for one cycle.
        we0 = 1; waddr0 = 1; wdata0 = 8'hAA; we1 = 1; waddr1 = 1; wdata1 = 8'hBB;
        raddr0 = 1;
        #1;
        expect_val(A_RD0, 8'hBB, "conf_byp_prio");
        expect_val(B_RD0, 8'h33, "conf_nobyp_old");
        flush();
        tick();
        clear_in();
        expect_val(A_RD0, 8'hBB, "conf_r1");
        expect_val(B_RD0, 8'hBB, "conf_b_r1");
        expect_val(A_CONF, 8'h01, "conf_flag");
        flush();
        tick();
        expect_val(A_CONF, 8'h00, "conf_clear");
        flush();

        // PC wrap, load-over-inc, stall-over-load.
        pc_load = 1; pc_load_val = 8'hFE;
        tick();
        clear_in();
        expect_val(A_PC, 8'hFE, "pc_load_fe");
        flush();
        pc_inc = 1;
        #1;
        expect_val(A_PCN, 8'hFF, "pcn_inc");
        flush();
        tick();
        expect_val(A_PC, 8'hFF, "pc_ff");
        flush();
        tick();
        expect_val(A_PC, 8'h00, "pc_wrap");
        flush();
        tick();
        expect_val(A_PC, 8'h01, "pc_01");
        flush();
        pc_load = 1; pc_load_val = 8'h40;
        #1;
        expect_val(A_PCN, 8'h40, "pcn_load_prio");
        flush();
        tick();
        expect_val(A_PC, 8'h40, "pc_load_prio");
        flush();
        stall = 1; pc_load_val = 8'h99;
        #1;
        expect_val(A_PCN, 8'h40, "pcn_stall");
        flush();
        tick();
        expect_val(A_PC, 8'h40, "pc_stall");
        expect_val(A_PCN, 8'h40, "pcn_stall_hold");
        flush();
        clear_in();

        // Hardwired R0 and out-of-range writes on the 3-register instance.
        we0 = 1; waddr0 = 0; wdata0 = 8'h77; we1 = 1; waddr1 = 3; wdata1 = 8'h77;
        raddr0 = 0; raddr1 = 3;
        #1;
        expect_val(C_RD0, 8'h00, "c_r0_byp");
        expect_val(C_RD1, 8'h00, "c_oor_byp");
        expect_val(A_RD0, 8'h77, "a_r0_byp");
        flush();
        tick();
        clear_in();
        expect_val(C_RD0, 8'h00, "c_r0_after");
        expect_val(C_RD1, 8'h00, "c_oor_after");
        expect_val(A_RD0, 8'h77, "a_r0_after");
        expect_val(A_RD1, 8'h77, "a_r3_after");
        expect_val(C_CONF, 8'h00, "c_conf_distinct");
        flush();
        raddr1 = 2;
        #1;
        expect_val(C_RD1, 8'h11, "c_r2_kept");
        flush();

        we0 = 1; waddr0 = 0; wdata0 = 8'h01; we1 = 1; waddr1 = 0; wdata1 = 8'h02;
        tick();
        clear_in();
        expect_val(A_CONF, 8'h01, "a_conf_r0");
        expect_val(C_CONF, 8'h00, "c_conf_r0");
        expect_val(A_RD0, 8'h02, "a_r0_prio");
        flush();

        we0 = 1; waddr0 = 3; wdata0 = 8'h05; we1 = 1; waddr1 = 3; wdata1 = 8'h06;
        tick();
        clear_in();
        expect_val(A_CONF, 8'h01, "a_conf_r3");
        expect_val(C_CONF, 8'h00, "c_conf_oor");
        flush();

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
